// File: rtl/rr_ppe_arbiter_pkg.sv
// Shared definitions for the round-robin programmable priority arbiter.
// Holds the default geometry, the index typedef and the WIDTH/LOG_W relation check.
package rr_ppe_arbiter_pkg;

  localparam int unsigned DEF_LOG_W = 10;
  localparam int unsigned DEF_WIDTH = 1 << DEF_LOG_W;

  typedef logic [DEF_LOG_W-1:0] idx_t;

  // True when width is exactly 2**log_w, so pointer arithmetic wraps for free.
  function automatic bit width_ok(input int unsigned width, input int unsigned log_w);
    return (log_w > 0) && (log_w < 32) && (width == (32'd1 << log_w));
  endfunction

endpackage

// File: rtl/lsb_onehot_enc.sv
// Lowest-set-bit encoder: reports whether any bit is set and the index of the lowest one.
module lsb_onehot_enc
  import rr_ppe_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned LOG_W = DEF_LOG_W
) (
  input  logic [WIDTH-1:0] i_vec,
  output logic             o_any_c,
  output logic [LOG_W-1:0] o_idx_c
);

  // Scanning downward lets the lowest set bit overwrite any higher one.
  always_comb begin
    o_any_c = |i_vec;
    o_idx_c = '0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (i_vec[i]) o_idx_c = LOG_W'(i);
    end
  end

endmodule

// File: rtl/rr_ppe_arbiter.sv
// Round-robin programmable priority arbiter: input register, pointer-masked priority encode,
// output register, valid/ready handshakes on both sides and a rotating grant pointer.
module rr_ppe_arbiter
  import rr_ppe_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned LOG_W = DEF_LOG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_req_valid,
  output logic             o_req_ready_c,
  input  logic [WIDTH-1:0] i_req_vec,
  input  logic             i_ptr_load,
  input  logic [LOG_W-1:0] i_ptr_val,
  output logic             o_gnt_valid,
  input  logic             i_gnt_ready,
  output logic             o_gnt_found,
  output logic [LOG_W-1:0] o_gnt_idx,
  output logic [LOG_W-1:0] o_ptr_q
);

  typedef logic [LOG_W-1:0] ptr_t;

  if (!width_ok(WIDTH, LOG_W)) begin : g_cfg_err
    $error("rr_ppe_arbiter: WIDTH must equal 2**LOG_W");
  end

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_req;
  logic             r_gnt_valid;
  logic             r_gnt_found;
  ptr_t             r_gnt_idx;
  ptr_t             r_ptr;

  logic [WIDTH-1:0] w_mask;
  logic [WIDTH-1:0] w_hi;
  logic             w_hi_any;
  ptr_t             w_hi_idx;
  logic             w_raw_any;
  ptr_t             w_raw_idx;
  logic             w_found;
  ptr_t             w_idx;
  logic             w_adv;
  logic             w_req_ready;
  logic             w_load;

  // Thermometer mask selects requesters at or above the live pointer.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      w_mask[i] = (LOG_W'(i) >= r_ptr);
    end
  end

  assign w_hi = r_s1_req & w_mask;

  lsb_onehot_enc #(.WIDTH(WIDTH), .LOG_W(LOG_W)) u_enc_hi (
    .i_vec   (w_hi),
    .o_any_c (w_hi_any),
    .o_idx_c (w_hi_idx)
  );

  lsb_onehot_enc #(.WIDTH(WIDTH), .LOG_W(LOG_W)) u_enc_raw (
    .i_vec   (r_s1_req),
    .o_any_c (w_raw_any),
    .o_idx_c (w_raw_idx)
  );

  // Prefer the masked hit; fall back to the wrapped lowest request.
  assign w_found = w_hi_any | w_raw_any;
  assign w_idx   = w_hi_any ? w_hi_idx : (w_raw_any ? w_raw_idx : '0);

  assign w_adv       = r_s1_valid & (~r_gnt_valid | i_gnt_ready);
  assign w_req_ready = ~r_s1_valid | w_adv;
  assign w_load      = i_req_valid & w_req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_req   <= '0;
    end else if (w_load) begin
      r_s1_valid <= 1'b1;
      r_s1_req   <= i_req_vec;
    end else if (w_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt_valid <= 1'b0;
      r_gnt_found <= 1'b0;
      r_gnt_idx   <= '0;
    end else if (w_adv) begin
      r_gnt_valid <= 1'b1;
      r_gnt_found <= w_found;
      r_gnt_idx   <= w_idx;
    end else if (i_gnt_ready) begin
      r_gnt_valid <= 1'b0;
    end
  end

  // An explicit load wins over the post-grant advance; the wrap is the natural LOG_W overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_ptr_load) begin
      r_ptr <= i_ptr_val;
    end else if (w_adv && w_found) begin
      r_ptr <= LOG_W'(w_idx + LOG_W'(1));
    end
  end

  assign o_req_ready_c = w_req_ready;
  assign o_gnt_valid   = r_gnt_valid;
  assign o_gnt_found   = r_gnt_found;
  assign o_gnt_idx     = r_gnt_idx;
  assign o_ptr_q       = r_ptr;

endmodule

// File: tb/tb_rr_ppe_arbiter.sv
// Bench for rr_ppe_arbiter at WIDTH=16 with a transaction-level model, plus a default-size smoke run.
module tb_rr_ppe_arbiter;

  localparam int unsigned W  = 16;
  localparam int unsigned LW = 4;
  localparam int unsigned BW = 1024;
  localparam int unsigned BL = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [W-1:0]  req_vec = '0;
  logic          ptr_load = 1'b0;
  logic [LW-1:0] ptr_val = '0;
  logic          gnt_valid;
  logic          gnt_ready = 1'b1;
  logic          gnt_found;
  logic [LW-1:0] gnt_idx;
  logic [LW-1:0] ptr_q;

  logic          b_valid = 1'b0;
  logic          b_ready;
  logic [BW-1:0] b_vec = '0;
  logic          b_gvalid;
  logic          b_found;
  logic [BL-1:0] b_idx;
  logic [BL-1:0] b_ptr;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rr_ppe_arbiter #(.WIDTH(W), .LOG_W(LW)) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_req_valid   (req_valid),
    .o_req_ready_c (req_ready),
    .i_req_vec     (req_vec),
    .i_ptr_load    (ptr_load),
    .i_ptr_val     (ptr_val),
    .o_gnt_valid   (gnt_valid),
    .i_gnt_ready   (gnt_ready),
    .o_gnt_found   (gnt_found),
    .o_gnt_idx     (gnt_idx),
    .o_ptr_q       (ptr_q)
  );

  rr_ppe_arbiter u_dut_big (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_req_valid   (b_valid),
    .o_req_ready_c (b_ready),
    .i_req_vec     (b_vec),
    .i_ptr_load    (1'b0),
    .i_ptr_val     ('0),
    .o_gnt_valid   (b_gvalid),
    .i_gnt_ready   (1'b1),
    .o_gnt_found   (b_found),
    .o_gnt_idx     (b_idx),
    .o_ptr_q       (b_ptr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: two slots (held request, held result) and a pointer; grants by rotating search.
  logic         m_s1_v;
  logic [W-1:0] m_s1_req;
  logic         m_out_v;
  logic         m_found;
  int           m_idx;
  int           m_ptr;

  always @(posedge clk or negedge rst_n) begin : model
    bit adv, rdy, f;
    int g, j;
    if (!rst_n) begin
      m_s1_v   <= 1'b0;
      m_s1_req <= '0;
      m_out_v  <= 1'b0;
      m_found  <= 1'b0;
      m_idx    <= 0;
      m_ptr    <= 0;
    end else begin
      adv = m_s1_v && (!m_out_v || gnt_ready);
      rdy = !m_s1_v || adv;
      f = 1'b0;
      g = 0;
      if (adv) begin
        for (int k = 0; k < int'(W); k++) begin
          j = (m_ptr + k) % int'(W);
          if (!f && m_s1_req[j]) begin
            f = 1'b1;
            g = j;
          end
        end
        m_out_v <= 1'b1;
        m_found <= f;
        m_idx   <= g;
      end else if (gnt_ready) begin
        m_out_v <= 1'b0;
      end
      if (ptr_load) m_ptr <= int'(ptr_val);
      else if (adv && f) m_ptr <= (g + 1) % int'(W);
      if (req_valid && rdy) begin
        m_s1_v   <= 1'b1;
        m_s1_req <= req_vec;
      end else if (adv) begin
        m_s1_v <= 1'b0;
      end
    end
  end

  // Per-cycle compare plus a log of each newly presented grant.
  int lg_idx[$];
  int lg_found[$];
  int lg_ptr[$];
  bit p_gv, p_taken;

  always @(negedge clk) begin
    if (rst_n) begin
      chk("req_ready", 32'(req_ready), 32'(!m_s1_v || !m_out_v || gnt_ready));
      chk("gnt_valid", 32'(gnt_valid), 32'(m_out_v));
      if (m_out_v) begin
        chk("gnt_found", 32'(gnt_found), 32'(m_found));
        chk("gnt_idx", 32'(gnt_idx), 32'(m_idx));
      end
      chk("ptr_q", 32'(ptr_q), 32'(m_ptr));
      if (gnt_valid && (!p_gv || p_taken)) begin
        lg_idx.push_back(int'(gnt_idx));
        lg_found.push_back(int'(gnt_found));
        lg_ptr.push_back(int'(ptr_q));
      end
      p_gv    = gnt_valid;
      p_taken = gnt_valid && gnt_ready;
    end else begin
      p_gv    = 1'b0;
      p_taken = 1'b0;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) cyc();
  endtask

  task automatic send(input logic [W-1:0] v);
    bit done;
    done = 1'b0;
    req_valid = 1'b1;
    req_vec   = v;
    for (int t = 0; t < 20 && !done; t++) begin
      #1;
      if (req_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    if (!done) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_log(input int k, input int found, input int idx, input int ptr);
    if (k < lg_idx.size()) begin
      chk($sformatf("log%0d_found", k), 32'(lg_found[k]), 32'(found));
      chk($sformatf("log%0d_idx", k), 32'(lg_idx[k]), 32'(idx));
      chk($sformatf("log%0d_ptr", k), 32'(lg_ptr[k]), 32'(ptr));
    end else begin
      chk($sformatf("log%0d_missing", k), 32'(lg_idx.size()), 32'(k + 1));
    end
  endtask

  initial begin : stim
    int lsz;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc();

    // Reset state and zero request vector
    chk("rst_gnt_valid", 32'(gnt_valid), 32'd0);
    chk("rst_ptr_q", 32'(ptr_q), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    send(16'h0000);
    idle(3);
    chk_log(0, 0, 0, 0);

    // Rotation, back-to-back, with first-grant latency
    send(16'h8421);
    chk("lat_not_yet", 32'(gnt_valid), 32'd0);
    send(16'h8421);
    chk("lat_first", 32'(gnt_valid), 32'd1);
    chk("lat_first_idx", 32'(gnt_idx), 32'd0);
    repeat (3) send(16'h8421);
    idle(3);
    chk_log(1, 1, 0, 1);
    chk_log(2, 1, 5, 6);
    chk_log(3, 1, 10, 11);
    chk_log(4, 1, 15, 0);
    chk_log(5, 1, 0, 1);

    // Wrap after pointer load
    ptr_load = 1'b1;
    ptr_val  = 4'd14;
    cyc();
    ptr_load = 1'b0;
    chk("load_ptr14", 32'(ptr_q), 32'd14);
    send(16'h0006);
    idle(3);
    chk_log(6, 1, 1, 2);

    // Backpressure: two held, third stalled, then drained in order
    gnt_ready = 1'b0;
    send(16'h0010);
    send(16'h0100);
    req_valid = 1'b1;
    req_vec   = 16'h1000;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_hold_idx", 32'(gnt_idx), 32'd4);
      @(posedge clk);
      #1;
    end
    gnt_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    idle(4);
    chk_log(7, 1, 4, 5);
    chk_log(8, 1, 8, 9);
    chk_log(9, 1, 12, 13);

    // Pointer load on the same edge as a grant
    req_valid = 1'b1;
    req_vec   = 16'h0080;
    cyc();
    req_valid = 1'b0;
    ptr_load  = 1'b1;
    ptr_val   = 4'd3;
    cyc();
    ptr_load = 1'b0;
    chk("sim_ptr", 32'(ptr_q), 32'd3);
    chk("sim_idx", 32'(gnt_idx), 32'd7);
    send(16'h0011);
    idle(3);
    chk_log(11, 1, 4, 5);

    // Reset while both stages are full
    gnt_ready = 1'b0;
    send(16'h0001);
    send(16'h0002);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_gnt_valid", 32'(gnt_valid), 32'd0);
    chk("arst_ptr_q", 32'(ptr_q), 32'd0);
    chk("arst_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b1;
    gnt_ready = 1'b1;
    lsz = lg_idx.size();
    idle(3);
    chk("arst_no_stale", 32'(lg_idx.size()), 32'(lsz));
    send(16'h0004);
    idle(3);
    chk_log(lsz, 1, 2, 3);

    // Default-size smoke run
    b_vec       = '0;
    b_vec[1000] = 1'b1;
    b_valid     = 1'b1;
    cyc();
    b_valid = 1'b0;
    cyc();
    chk("big_valid", 32'(b_gvalid), 32'd1);
    chk("big_idx", 32'(b_idx), 32'd1000);
    chk("big_ptr", 32'(b_ptr), 32'd1001);
    b_vec    = '0;
    b_vec[3] = 1'b1;
    b_valid  = 1'b1;
    cyc();
    b_valid = 1'b0;
    cyc();
    chk("big_wrap_idx", 32'(b_idx), 32'd3);
    chk("big_wrap_ptr", 32'(b_ptr), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
